// File: rtl/kasumi_mem_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package kasumi_mem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and backing-memory signal bundle; slave is the arbiter's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ready, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ready, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch is waiting.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0] cnt;

  assign at_max = (cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing one backing memory between fetch and data ports,
// with a sticky snoop on stores to the tohost word.
module mem_arbiter
  import kasumi_mem_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              MEM_LAT     = 1,
  parameter int              STARVE_MAX  = 4,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_ADDR_DEF)
) (
  input  logic       clk,
  input  logic       rst,
  mem_arbiter_if.slave bus,
  output logic       stall_if,
  output logic       stall_mem,
  output logic       tohost_valid,
  output logic [7:0] tohost_data
);
  localparam int         BE_W     = DATA_W / 8;
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  arb_state_e        state, state_d;
  logic              owner;
  logic [3:0]        lat_cnt;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [BE_W-1:0]   cmd_be;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              grant_d, grant_i, at_max, lat_done;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (grant_d && bus.i_req),
    .clr    (grant_i || !bus.i_req),
    .at_max (at_max)
  );

  assign lat_done = (state == WAIT) && (lat_cnt == LAT_LAST);

  // Data has priority unless the fetch port has waited out its starvation budget.
  always_comb begin
    state_d = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && !(at_max && bus.i_req)) begin
          grant_d = 1'b1;
          state_d = GRANT;
        end else if (bus.i_req) begin
          grant_i = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT:   state_d = WAIT;
      WAIT:    if (lat_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWNER_I;
      lat_cnt      <= '0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      cmd_be       <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else begin
      state <= state_d;
      if (grant_d) begin
        owner     <= OWNER_D;
        cmd_we    <= bus.d_we;
        cmd_addr  <= bus.d_addr;
        cmd_wdata <= bus.d_wdata;
        cmd_be    <= bus.d_be;
      end else if (grant_i) begin
        owner     <= OWNER_I;
        cmd_we    <= 1'b0;
        cmd_addr  <= bus.i_addr;
        cmd_wdata <= '0;
        cmd_be    <= '0;
      end
      if (state == WAIT) lat_cnt <= lat_done ? 4'd0 : lat_cnt + 4'd1;
      // Read data is taken on entry to RESP so it is already valid with the ready pulse.
      if (lat_done && !cmd_we) begin
        if (owner == OWNER_I) i_rdata_q <= bus.mem_rdata;
        else                  d_rdata_q <= bus.mem_rdata;
      end
      if (state == RESP && owner == OWNER_D && cmd_we && cmd_addr == TOHOST_ADDR &&
          cmd_be[0] && !tohost_valid) begin
        tohost_valid <= 1'b1;
        tohost_data  <= cmd_wdata[7:0];
      end
    end
  end

  assign bus.mem_en    = (state == GRANT);
  assign bus.mem_we    = (state == GRANT) && cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.mem_be    = cmd_be;

  assign bus.i_ready = (state == RESP) && (owner == OWNER_I);
  assign bus.d_ready = (state == RESP) && (owner == OWNER_D);
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  assign stall_if  = bus.i_req && !rst && !bus.i_ready;
  assign stall_mem = bus.d_req && !rst && !bus.d_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level memory/arbitration model.
module tb_mem_arbiter;
  localparam int LAT = 1;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  logic       stall_if, stall_mem, tohost_valid;
  logic [7:0] tohost_data;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX), .TOHOST_ADDR(32'h1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data)
  );

  // Backing memory driven by the DUT
  logic [31:0] mem_arr [0:2047];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem_arr[bus.mem_addr[12:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem_arr[bus.mem_addr[12:2]];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:2047];
  logic        ref_th;
  logic [7:0]  ref_thd;
  logic [31:0] last_d;
  int          n_chk = 0;
  int          n_err = 0;
  int          g_first_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[12:2]);
  endfunction

  task automatic drive_idle();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
  endtask

  // One round: optional fetch and data request raised together, each held until its ready.
  task automatic run_round(input bit di, input bit dd, input bit dwe,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [3:0] be);
    int exp_i, exp_d, cyc, n_en;
    logic [31:0] exp_idata, exp_ddata;
    bit ip, dp;
    exp_idata = '0;
    exp_ddata = '0;
    exp_d = dd ? LAT + 2 : -1;
    exp_i = di ? (dd ? (LAT + 3) + (LAT + 2) : LAT + 2) : -1;
    // data is served first, so a fetch in the same round observes its store
    if (dd) begin
      if (dwe) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[widx(da)][8*b +: 8] = wd[8*b +: 8];
        if (da == 32'h1000 && be[0] && !ref_th) begin
          ref_th  = 1'b1;
          ref_thd = wd[7:0];
        end
        exp_ddata = last_d;
      end else begin
        exp_ddata = ref_mem[widx(da)];
      end
      last_d = exp_ddata;
    end
    if (di) exp_idata = ref_mem[widx(ia)];

    @(negedge clk);
    bus.i_req = di; bus.i_addr = ia;
    bus.d_req = dd; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = wd; bus.d_be = be;
    ip = di; dp = dd; cyc = 0; n_en = 0; g_first_en = -1;
    while ((ip || dp) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_en) begin
        n_en++;
        if (g_first_en < 0) g_first_en = cyc;
      end
      if (ip) chk("stall_if", stall_if, cyc != exp_i);
      if (dp) chk("stall_mem", stall_mem, cyc != exp_d);
      chk("i_ready", bus.i_ready, ip && cyc == exp_i);
      chk("d_ready", bus.d_ready, dp && cyc == exp_d);
      if (bus.i_ready && ip) begin
        chk("i_rdata", bus.i_rdata, exp_idata);
        ip = 1'b0;
        bus.i_req = 1'b0;
      end
      if (bus.d_ready && dp) begin
        chk("d_rdata", bus.d_rdata, exp_ddata);
        dp = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    chk("round_pending", {30'b0, ip, dp}, 32'b0);
    chk("mem_en_cnt", n_en, int'(di) + int'(dd));
    @(negedge clk);
    chk("stall_idle", {stall_if, stall_mem}, 2'b00);
    chk("tohost_valid", tohost_valid, ref_th);
    chk("tohost_data", tohost_data, ref_thd);
  endtask

  // Fetch and data both held: expect SMAX data grants per fetch grant.
  task automatic starve_test();
    int sc, n, cyc;
    bit exp_fetch;
    sc = 0; n = 0; cyc = 0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h204;
    while (n < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_en) begin
        exp_fetch = (sc == SMAX);
        chk("starve_owner", bus.mem_addr == 32'h200, exp_fetch);
        sc = exp_fetch ? 0 : sc + 1;
        n++;
      end
    end
    chk("starve_grants", n, 10);
    drive_idle();
    repeat (5) @(negedge clk);
    last_d = ref_mem[widx(32'h204)];
  endtask

  task automatic mid_reset_test();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    @(negedge clk);
    chk("midrst_grant", bus.mem_en, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_en", bus.mem_en, 1'b0);
    chk("midrst_rdy", bus.d_ready, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_quiet", {bus.d_ready, bus.i_ready, bus.mem_en}, 3'b000);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    ref_th = 1'b0; ref_thd = '0; last_d = '0;
    run_round(0, 1, 0, 32'h0, 32'h10, 32'h0, 4'h0);
  endtask

  initial begin
    bit di, dd;
    for (int i = 0; i < 2048; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[widx(32'h40)] = 32'h0000_0013;
    ref_mem[widx(32'h40)] = 32'h0000_0013;
    ref_th = 1'b0; ref_thd = '0; last_d = '0;
    drive_idle();
    rst = 1'b1;

    repeat (6) begin
      @(negedge clk);
      bus.i_req = 1'($urandom); bus.d_req = 1'($urandom); bus.d_we = 1'($urandom);
      bus.i_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_be = 4'($urandom);
      #1;
      chk("rst_ctrl", {bus.i_ready, bus.d_ready, bus.mem_en, bus.mem_we, stall_if, stall_mem, tohost_valid}, 7'b0);
      chk("rst_data", bus.i_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata |
                      {24'b0, tohost_data} | {28'b0, bus.mem_be}, 32'b0);
    end
    @(negedge clk);
    drive_idle();
    rst = 1'b0;

    run_round(1, 0, 0, 32'h40, 32'h0, 32'h0, 4'h0);
    chk("fetch_en_cyc", g_first_en, 1);
    chk("fetch_word", bus.i_rdata, 32'h0000_0013);

    run_round(1, 1, 0, 32'h44, 32'h80, 32'h0, 4'h0);

    run_round(0, 1, 1, 32'h0, 32'h100, 32'hDEAD_BEEF, 4'hF);
    run_round(1, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0);
    chk("coh_word", bus.i_rdata, 32'hDEAD_BEEF);

    run_round(0, 1, 1, 32'h0, 32'h1000, 32'h0000_0001, 4'hF);
    chk("tohost_set", {tohost_valid, tohost_data}, {1'b1, 8'h01});
    run_round(0, 1, 1, 32'h0, 32'h1000, 32'h0000_0002, 4'hF);
    chk("tohost_sticky", {tohost_valid, tohost_data}, {1'b1, 8'h01});

    starve_test();
    mid_reset_test();

    for (int r = 0; r < 60; r++) begin
      logic [31:0] ia, da;
      di = 1'($urandom);
      dd = 1'($urandom);
      if (!di && !dd) di = 1'b1;
      ia = 32'($urandom_range(0, 63)) << 2;
      da = ($urandom_range(0, 9) == 0) ? 32'h1000 : 32'($urandom_range(0, 63)) << 2;
      run_round(di, dd, 1'($urandom), ia, da, $urandom, 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
